// File: rtl/sram_frame_reader_if.sv
// SRAM controller read port and output word stream of sram_frame_reader.
// The master side is the reader; the slave side is the controller plus consumer.
interface sram_frame_reader_if #(parameter int AW = 19);
  logic          selec;
  logic          write;
  logic          read;
  logic [AW-1:0] addr_wr;
  logic [15:0]   data_wr_out;
  logic [15:0]   out_data;
  logic          out_valid;
  logic          out_ready;

  modport master (
    output selec, write, read, addr_wr, out_data, out_valid,
    input  data_wr_out, out_ready
  );

  modport slave (
    input  selec, write, read, addr_wr, out_data, out_valid,
    output data_wr_out, out_ready
  );
endinterface

// File: rtl/sram_frame_reader.sv
// Read-only SRAM client: fetches a block of words on start and streams them
// out through a small show-ahead FIFO with valid/ready.
module sram_frame_reader #(
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int AW         = 19
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [AW-1:0]       base_addr,
  input  logic [AW-1:0]       word_cnt,
  output logic                busy,
  output logic                done,
  sram_frame_reader_if.master bus
);

  localparam int PW       = $clog2(FIFO_DEPTH);
  localparam int LW       = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int LAST_LAT = RD_LAT - 1;
  localparam logic [PW:0]   FULL_CNT = FIFO_DEPTH[PW:0];
  localparam logic [LW-1:0] LAT_END  = LAST_LAT[LW-1:0];

  typedef enum logic [2:0] {IDLE, CHECK, READ, CAPTURE, FINISH} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] rem_q, rem_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [15:0]   mem_q [FIFO_DEPTH];
  logic          push;
  logic          pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      rem_q    <= '0;
      lat_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      rem_q    <= rem_d;
      lat_q    <= lat_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.data_wr_out;
    end
  end

  // CHECK only checks the registered occupancy: pops can only free slots
  // before the push in CAPTURE, so the FIFO can never overflow.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    rem_d     = rem_q;
    lat_d     = lat_q;
    push      = 1'b0;
    done      = 1'b0;
    bus.selec = 1'b0;
    bus.read  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          ptr_d   = base_addr;
          rem_d   = word_cnt;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (rem_q == '0) begin
          state_d = FINISH;
        end else if (count_q < FULL_CNT) begin
          lat_d   = '0;
          state_d = READ;
        end
      end
      READ: begin
        bus.selec = 1'b1;
        bus.read  = 1'b1;
        if (lat_q == LAT_END) begin
          state_d = CAPTURE;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      CAPTURE: begin
        bus.selec = 1'b1;
        bus.read  = 1'b1;
        push      = 1'b1;
        ptr_d     = ptr_q + 1'b1;
        rem_d     = rem_q - 1'b1;
        state_d   = CHECK;
      end
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pop      = bus.out_ready && (count_q != '0);
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  assign busy          = (state_q != IDLE);
  assign bus.write     = 1'b0;
  assign bus.addr_wr   = ptr_q;
  assign bus.out_valid = (count_q != '0);
  assign bus.out_data  = bus.out_valid ? mem_q[rd_ptr_q] : 16'h0000;

endmodule
